// File: rtl/pc_sequencer.sv
// Purpose : program-counter controller; fetches over req/ack, holds instr until retire, picks next PC.
// Latency : 1 BOOT cycle after reset, then 2 cycles per instruction with zero-wait ack (FETCH + EXEC).
// Backpr. : imem_req held with a stable address until imem_ack; instr held valid until dec_done.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req/imem_addr              fetch request and address (address always equals pc)
//   imem_ack/imem_data              memory acknowledge, data valid in the ack cycle
//   instr_valid/instr               latched instruction presented to the decoder
//   dec_done                        decoder retires instr; redirect inputs valid this cycle
//   jump_req/jump_target            absolute redirect from the jump address unit
//   branch_req/branch_taken/branch_off  PC-relative redirect (signed offset from pc+1)
//   halt_req                        retiring instruction stops the core
//   pc, halted, retired             current PC, halt status, retired-instruction count
module pc_sequencer #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [7:0]    imem_data,
    output logic          instr_valid,
    output logic [7:0]    instr,
    input  logic          dec_done,
    input  logic          jump_req,
    input  logic [AW-1:0] jump_target,
    input  logic          branch_req,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_off,
    input  logic          halt_req,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic [CW-1:0] retired
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] pc_seq;
    logic [AW-1:0] pc_branch;
    logic          instr_load;
    logic          retire;

    // The offset is as wide as the PC, so a plain modular add of the
    // two's-complement value is the same as sign-extending it.
    assign pc_seq    = pc + AW'(1);
    assign pc_branch = pc_seq + branch_off;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (instr_load) begin
                instr <= imem_data;
            end
            if (retire) begin
                retired <= retired + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, next-PC and register enables
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_load = 1'b0;
        retire     = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                // pc is not touched here so the address stays stable
                // for the whole request, however long memory stalls.
                if (imem_ack) begin
                    instr_load = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (dec_done) begin
                    retire = 1'b1;
                    if (halt_req) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = FETCH;
                        if (jump_req) begin
                            pc_nxt = jump_target;
                        end else if (branch_req && branch_taken) begin
                            pc_nxt = pc_branch;
                        end else begin
                            pc_nxt = pc_seq;
                        end
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // rst_n gates the request directly so it falls in the same instant the
    // reset is asserted, without relying on the state flop's clear path.
    assign imem_req    = rst_n && (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer against a behavioural PC/retire model.
// Latency : n/a (testbench).
// Backpr. : memory ack delay and decoder hold time are varied by the stimulus.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic       dec_done;
    logic       jump_req;
    logic [7:0] jump_target;
    logic       branch_req;
    logic       branch_taken;
    logic [7:0] branch_off;
    logic       halt_req;
    logic [7:0] pc;
    logic       halted;
    logic [15:0] retired;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int       m_pc;
    int       m_ret;
    bit       m_halt;
    logic [7:0] m_instr;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .dec_done     (dec_done),
        .jump_req     (jump_req),
        .jump_target  (jump_target),
        .branch_req   (branch_req),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .halt_req     (halt_req),
        .pc           (pc),
        .halted       (halted),
        .retired      (retired)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack     = 1'b0;
        imem_data    = 8'h00;
        dec_done     = 1'b0;
        jump_req     = 1'b0;
        jump_target  = 8'h00;
        branch_req   = 1'b0;
        branch_taken = 1'b0;
        branch_off   = 8'h00;
        halt_req     = 1'b0;
    endtask

    // Reset, release, and advance past BOOT; leaves the DUT in its first FETCH.
    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n   = 1'b1;
        m_pc    = 0;
        m_ret   = 0;
        m_halt  = 1'b0;
        m_instr = 8'h00;
        step();
    endtask

    // Fetch one instruction with 'delay' wait cycles before ack.
    // Optionally drives a spurious dec_done+jump during the wait cycles.
    task automatic fetch(input int delay, input bit spurious);
        logic [7:0] d;
        tests_run++;
        if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL fetch_req: got %b expected 1 (pc model %0h)", imem_req, m_pc); end
        tests_run++;
        if (imem_addr !== 8'(m_pc)) begin tests_failed++; $display("FAIL fetch_addr: got %0h expected %0h", imem_addr, 8'(m_pc)); end
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_valid: got %b expected 0", instr_valid); end
        for (int i = 0; i < delay; i++) begin
            imem_data = 8'($urandom);
            if (spurious) begin
                dec_done    = 1'b1;
                jump_req    = 1'b1;
                jump_target = 8'($urandom);
            end
            step();
            clear_inputs();
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc)) begin
                tests_failed++;
                $display("FAIL wait_hold: req=%b addr=%0h expected req=1 addr=%0h", imem_req, imem_addr, 8'(m_pc));
            end
            tests_run++;
            if (retired !== 16'(m_ret) || instr !== m_instr) begin
                tests_failed++;
                $display("FAIL wait_state: retired=%0d instr=%0h expected retired=%0d instr=%0h", retired, instr, 16'(m_ret), m_instr);
            end
        end
        d         = 8'($urandom);
        imem_ack  = 1'b1;
        imem_data = d;
        step();
        clear_inputs();
        m_instr = d;
        tests_run++;
        if (instr_valid !== 1'b1 || instr !== m_instr) begin
            tests_failed++;
            $display("FAIL exec_instr: valid=%b instr=%0h expected valid=1 instr=%0h", instr_valid, instr, m_instr);
        end
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL exec_req: got %b expected 0", imem_req); end
    endtask

    // Hold in EXEC for 'hold' cycles (optionally with spurious acks), then retire.
    task automatic retire(input int hold, input bit spurious_ack,
                          input bit jmp, input logic [7:0] tgt,
                          input bit br, input bit tk, input logic [7:0] off,
                          input bit hlt);
        int o;
        for (int i = 0; i < hold; i++) begin
            if (spurious_ack) begin
                imem_ack  = 1'b1;
                imem_data = ~m_instr;
            end
            step();
            clear_inputs();
            tests_run++;
            if (instr_valid !== 1'b1 || instr !== m_instr || imem_req !== 1'b0 || retired !== 16'(m_ret)) begin
                tests_failed++;
                $display("FAIL exec_hold: valid=%b instr=%0h req=%b retired=%0d expected 1 %0h 0 %0d",
                         instr_valid, instr, imem_req, retired, m_instr, 16'(m_ret));
            end
        end
        dec_done     = 1'b1;
        jump_req     = jmp;
        jump_target  = tgt;
        branch_req   = br;
        branch_taken = tk;
        branch_off   = off;
        halt_req     = hlt;
        step();
        clear_inputs();
        m_ret = (m_ret + 1) % 65536;
        if (hlt) begin
            m_halt = 1'b1;
        end else if (jmp) begin
            m_pc = int'(tgt);
        end else if (br && tk) begin
            o    = (int'(off) >= 128) ? int'(off) - 256 : int'(off);
            m_pc = (m_pc + 1 + o + 512) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
        tests_run++;
        if (retired !== 16'(m_ret)) begin tests_failed++; $display("FAIL retire_count: got %0d expected %0d", retired, m_ret); end
        tests_run++;
        if (pc !== 8'(m_pc)) begin tests_failed++; $display("FAIL retire_pc: got %0h expected %0h", pc, 8'(m_pc)); end
        tests_run++;
        if (halted !== m_halt || imem_req !== !m_halt || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL retire_ctl: halted=%b req=%b valid=%b expected halted=%b req=%b valid=0",
                     halted, imem_req, instr_valid, m_halt, !m_halt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        tests_run++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: req=%b valid=%b halted=%b expected all 0", imem_req, instr_valid, halted);
        end
        tests_run++;
        if (pc !== 8'h00 || imem_addr !== 8'h00 || instr !== 8'h00 || retired !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: pc=%0h addr=%0h instr=%0h retired=%0d expected 0", pc, imem_addr, instr, retired);
        end
        rst_n = 1'b1;
        m_pc = 0; m_ret = 0; m_halt = 1'b0; m_instr = 8'h00;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL boot_noreq: got %b expected 0", imem_req); end
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_fetch: req=%b addr=%0h expected req=1 addr=00", imem_req, imem_addr);
        end
    endtask

    // Sequential fetch of 00,01,02, then a jump from 02 to 04.
    task automatic test_sequential_and_jump();
        fetch(0, 1'b0); retire(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch(0, 1'b0); retire(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0);
        tests_run++;
        if (retired !== 16'd3 || pc !== 8'h04) begin
            tests_failed++;
            $display("FAIL seq_jump: retired=%0d pc=%0h expected 3 04", retired, pc);
        end
        fetch(0, 1'b0);
    endtask

    // Backward branch from 00 by -2 lands on FF, then sequential wraps to 00.
    task automatic test_branch_wrap();
        reset_dut();
        fetch(0, 1'b0); retire(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0);
        tests_run++;
        if (pc !== 8'hFF) begin tests_failed++; $display("FAIL branch_back: got %0h expected ff", pc); end
        fetch(0, 1'b0); retire(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 1'b0);
        tests_run++;
        if (pc !== 8'h00) begin tests_failed++; $display("FAIL pc_wrap: got %0h expected 00", pc); end
        fetch(0, 1'b0);
    endtask

    // Jump beats taken branch; halt beats both and freezes the core.
    task automatic test_priority_halt();
        int r;
        reset_dut();
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h05, 1'b0);
        tests_run++;
        if (pc !== 8'h10) begin tests_failed++; $display("FAIL jump_priority: got %0h expected 10", pc); end
        reset_dut();
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h05, 1'b1);
        tests_run++;
        if (pc !== 8'h03 || halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_priority: pc=%0h halted=%b expected 03 1", pc, halted);
        end
        r = m_ret;
        for (int i = 0; i < 5; i++) begin
            imem_ack    = 1'b1;
            imem_data   = 8'($urandom);
            dec_done    = 1'b1;
            jump_req    = 1'b1;
            jump_target = 8'($urandom);
            step();
            clear_inputs();
            tests_run++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'h03 || retired !== 16'(r)) begin
                tests_failed++;
                $display("FAIL halt_frozen: req=%b valid=%b halted=%b pc=%0h retired=%0d expected 0 0 1 03 %0d",
                         imem_req, instr_valid, halted, pc, retired, r);
            end
        end
    endtask

    // 3-cycle ack delay with spurious dec_done in FETCH and spurious ack in EXEC.
    task automatic test_wait_states();
        reset_dut();
        fetch(3, 1'b1);
        retire(2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch(1, 1'b0);
    endtask

    // Reset asserted while fetching at 07.
    task automatic test_reset_midfetch();
        reset_dut();
        fetch(0, 1'b0); retire(0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        imem_data = 8'h5A;
        step();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h07) begin
            tests_failed++;
            $display("FAIL pre_reset_fetch: req=%b addr=%0h expected 1 07", imem_req, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || pc !== 8'h00 || retired !== 16'h0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL midfetch_reset: req=%b pc=%0h retired=%0d valid=%b halted=%b expected 0 00 0 0 0",
                     imem_req, pc, retired, instr_valid, halted);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        m_pc = 0; m_ret = 0; m_halt = 1'b0; m_instr = 8'h00;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL post_reset_boot: got %b expected 0", imem_req); end
        step();
        fetch(0, 1'b0);
    endtask

    // Random instruction stream with random waits and redirects.
    task automatic test_random();
        bit hlt;
        reset_dut();
        for (int n = 0; n < 250; n++) begin
            fetch(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            hlt = ($urandom_range(0, 39) == 0);
            retire(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), 8'($urandom),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom),
                   hlt);
            if (hlt) begin
                step();
                tests_run++;
                if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'(m_pc)) begin
                    tests_failed++;
                    $display("FAIL rand_halt: halted=%b req=%b pc=%0h expected 1 0 %0h", halted, imem_req, pc, 8'(m_pc));
                end
                reset_dut();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential_and_jump();
        test_branch_wrap();
        test_priority_halt();
        test_wait_states();
        test_reset_midfetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
